fifo_wr_arbiter: RTL

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

---
 rtl/fifo_wr_arbiter.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
//
// Two-requester round-robin write arbiter in front of a FIFO, with occupancy
// tracking and a drain (flush) sequencer.
//
// Parameters
//   WIDTH  data width of both requesters and the FIFO write port
//   DEPTH  entry capacity of the attached FIFO
//   CW     occupancy counter width, $clog2(DEPTH+1)
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   valid0/1, data0/1   requester write offers
//   ready0/1            requester word accepted this cycle (with valid)
//   rd_req              consumer asks for one FIFO read
//   flush               single-cycle request to drain the FIFO
//   wr_en, wr_data      FIFO write strobe and data
//   rd_en               FIFO read strobe
//   count, full, empty  FIFO occupancy and its boundary flags
//   busy                high while draining
//   flush_done          one-cycle pulse on the final (empty) drain cycle
//   gnt_cnt0/1          per-requester write counters
//
// Build option
//   FIFO_ARB_GNT_CNT_EN  when defined, gnt_cnt0/1 count writes per requester
//                        (saturating at 255, cleared only by reset); otherwise
//                        both ports are tied to zero.

module fifo_wr_arbiter #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8,
  localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid0,
  input  logic [WIDTH-1:0] data0,
  input  logic             valid1,
  input  logic [WIDTH-1:0] data1,
  output logic             ready0,
  output logic             ready1,
  input  logic             rd_req,
  input  logic             flush,
  output logic             wr_en,
  output logic [WIDTH-1:0] wr_data,
  output logic             rd_en,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty,
  output logic             busy,
  output logic             flush_done,
  output logic [7:0]       gnt_cnt0,
  output logic [7:0]       gnt_cnt1
);

  localparam logic [CW-1:0] DepthC = CW'(DEPTH);

  typedef enum logic [0:0] {
    StRun,
    StFlush
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  // High when requester 1 won the most recent accepted write, so requester 0
  // wins the next tie.
  logic          last_gnt_q, last_gnt_d;

  logic          gnt0, gnt1;

  assign count = count_q;
  assign full  = (count_q == DepthC);
  assign empty = (count_q == '0);

  // ---------------------------------------------------------------------------
  // Arbitration, handshakes and FSM next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    gnt0       = 1'b0;
    gnt1       = 1'b0;
    ready0     = 1'b0;
    ready1     = 1'b0;
    rd_en      = 1'b0;
    busy       = 1'b0;
    flush_done = 1'b0;

    case (state_q)
      StRun: begin
        if (valid0 && valid1) begin
          gnt0 = last_gnt_q;
          gnt1 = !last_gnt_q;
        end else begin
          gnt0 = valid0;
          gnt1 = valid1;
        end
        // rst_n gating keeps the handshakes quiet while reset is held even if
        // requesters are already presenting data.
        ready0 = rst_n && gnt0 && !full;
        ready1 = rst_n && gnt1 && !full;
        rd_en  = rst_n && rd_req && !empty;
        if (flush) begin
          state_d = StFlush;
        end
      end

      StFlush: begin
        busy  = 1'b1;
        rd_en = !empty;
        if (empty) begin
          flush_done = 1'b1;
          state_d    = StRun;
        end
      end

      default: begin
        state_d = StRun;
      end
    endcase
  end

  // Write port: zero-latency pass-through of the granted requester.
  always_comb begin
    wr_en   = (valid0 && ready0) || (valid1 && ready1);
    wr_data = '0;
    if (wr_en) begin
      wr_data = gnt1 ? data1 : data0;
    end
  end

  // Round-robin pointer moves only on an accepted write.
  always_comb begin
    last_gnt_d = last_gnt_q;
    if (wr_en) begin
      last_gnt_d = gnt1;
    end
  end

  // Occupancy: a simultaneous read and write cancel. Bounds are guaranteed
  // because writes are blocked at full and reads are blocked at empty.
  always_comb begin
    count_d = count_q;
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StRun;
      count_q    <= '0;
      last_gnt_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      last_gnt_q <= last_gnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Optional per-requester grant counters
  // ---------------------------------------------------------------------------
`ifdef FIFO_ARB_GNT_CNT_EN
  logic [7:0] gnt_cnt0_q, gnt_cnt0_d;
  logic [7:0] gnt_cnt1_q, gnt_cnt1_d;

  always_comb begin
    gnt_cnt0_d = gnt_cnt0_q;
    gnt_cnt1_d = gnt_cnt1_q;
    if (wr_en && gnt0 && (gnt_cnt0_q != 8'hFF)) begin
      gnt_cnt0_d = gnt_cnt0_q + 8'd1;
    end
    if (wr_en && gnt1 && (gnt_cnt1_q != 8'hFF)) begin
      gnt_cnt1_d = gnt_cnt1_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_cnt0_q <= 8'd0;
      gnt_cnt1_q <= 8'd0;
    end else begin
      gnt_cnt0_q <= gnt_cnt0_d;
      gnt_cnt1_q <= gnt_cnt1_d;
    end
  end

  assign gnt_cnt0 = gnt_cnt0_q;
  assign gnt_cnt1 = gnt_cnt1_q;
`else
  assign gnt_cnt0 = 8'd0;
  assign gnt_cnt1 = 8'd0;
`endif

endmodule
